// File: rtl/irq_ctl.sv
// irq_ctl: 8-source rising-edge interrupt controller with a 32-byte memory-mapped register window.
// Define IRQ_CTL_COUNT_EN to add the edge COUNT register at offset 0x10.
module irq_ctl #(
    parameter logic [31:0] BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  src,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);
    logic [7:0]  src_q;
    logic [7:0]  pending;
    logic [7:0]  mask;
    logic [7:0]  rise;
    logic [7:0]  clr;
    logic [7:0]  status;
    logic [2:0]  sel;
    logic        wr;
    logic [4:0]  idx;
    logic [31:0] id;
    logic [31:0] cnt_val;
    logic [31:0] reg_val;
    logic        unused;

    assign hit    = memAddr[31:5] == BASE[31:5];
    assign sel    = memAddr[4:2];
    assign wr     = hit & MemWrite;
    assign rise   = src & ~src_q;
    assign clr    = (wr && sel == 3'd0) ? memWriteData[7:0] : 8'd0;
    assign status = pending & mask;
    assign id     = {|status, 26'd0, idx};
    assign unused = ^{memAddr[1:0], memWriteData[31:8]};

    always_comb begin
        idx = 5'd0;
        for (int i = 7; i >= 0; i--)
            if (status[i]) idx = i[4:0];
    end

`ifdef IRQ_CTL_COUNT_EN
    logic [31:0] count;
    assign cnt_val = count;
    always_ff @(posedge clk)
        if (reset)
            count <= 32'd0;
        else
            count <= (wr && sel == 3'd4) ? 32'd0 : count + {31'd0, |rise};
`else
    assign cnt_val = 32'd0;
`endif

    always_comb
        reg_val = sel == 3'd0 ? {24'd0, pending} :
                  sel == 3'd1 ? {24'd0, mask} :
                  sel == 3'd2 ? {24'd0, status} :
                  sel == 3'd3 ? id :
                  sel == 3'd4 ? cnt_val : 32'd0;

    assign rdata = (hit & MemRead) ? reg_val : 32'd0;

    // src_q resets high so sources already asserted at reset release are not seen as edges
    always_ff @(posedge clk)
        if (reset) begin
            src_q   <= 8'hFF;
            pending <= 8'd0;
            mask    <= 8'd0;
            irq     <= 1'b0;
        end else begin
            src_q   <= src;
            pending <= (pending & ~clr) | rise;
            mask    <= (wr && sel == 3'd1) ? memWriteData[7:0] : mask;
            irq     <= |status;
        end
endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: scoreboard bench for irq_ctl; expected values are queued with stimulus and popped at sampling.
module tb_irq_ctl;
    localparam logic [31:0] B = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  src = 8'h00;
    logic [31:0] memAddr = 32'd0;
    logic [31:0] memWriteData = 32'd0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int vecs = 0;
    int errs = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [31:0] v;
    logic        h;

    irq_ctl #(.BASE(B)) dut (
        .clk(clk), .reset(reset), .src(src), .memAddr(memAddr),
        .memWriteData(memWriteData), .MemRead(MemRead), .MemWrite(MemWrite),
        .rdata(rdata), .hit(hit), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memAddr = a; memWriteData = d; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic hv);
        memAddr = a; MemRead = 1'b1;
        #1;
        d = rdata; hv = hit;
        MemRead = 1'b0;
    endtask

    task automatic test_reset;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        reset = 1'b1; src = 8'h01; memAddr = B + 4; memWriteData = 32'hFF; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; reset = 1'b0;
        rd(B, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL reset_pending got=%h want=%h", v, e); end
        rd(B + 4, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL reset_mask got=%h want=%h", v, e); end
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, irq} !== e) begin errs++; $display("FAIL reset_irq got=%b want=%h", irq, e); end
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        wr(B + 4, 32'h01);
        repeat (3) @(negedge clk);
        rd(B, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL held_src_pending got=%h want=%h", v, e); end
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, irq} !== e) begin errs++; $display("FAIL held_src_irq got=%b want=%h", irq, e); end
    endtask

    task automatic test_edge;
        wr(B + 4, 32'h04);
        src = 8'h00;
        @(negedge clk);
        src = 8'h04;
        exp_q.push_back(32'h04); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        exp_q.push_back(32'h8000_0002); exp_q.push_back(32'h04);
        @(negedge clk);
        rd(B, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL edge_pending got=%h want=%h", v, e); end
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, irq} !== e) begin errs++; $display("FAIL edge_irq_k got=%b want=%h", irq, e); end
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, irq} !== e) begin errs++; $display("FAIL edge_irq_k1 got=%b want=%h", irq, e); end
        rd(B + 12, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL edge_id got=%h want=%h", v, e); end
        rd(B + 8, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL edge_status got=%h want=%h", v, e); end
    endtask

    task automatic test_w1c;
        wr(B + 4, 32'hFF);
        src = 8'h00;
        @(negedge clk);
        src = 8'h0C;
        repeat (2) @(negedge clk);
        exp_q.push_back(32'h0C); exp_q.push_back(32'h08); exp_q.push_back(32'h8000_0003);
        exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        rd(B, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL w1c_pre got=%h want=%h", v, e); end
        wr(B, 32'h04);
        rd(B, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL w1c_pending got=%h want=%h", v, e); end
        rd(B + 12, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL w1c_id got=%h want=%h", v, e); end
        wr(B, 32'h08);
        rd(B, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL w1c_empty got=%h want=%h", v, e); end
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, irq} !== e) begin errs++; $display("FAIL w1c_irq_lag got=%b want=%h", irq, e); end
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, irq} !== e) begin errs++; $display("FAIL w1c_irq_drop got=%b want=%h", irq, e); end
    endtask

    task automatic test_same_cycle;
        src = 8'h00;
        @(negedge clk);
        src = 8'h02;
        @(negedge clk);
        src = 8'h00;
        @(negedge clk);
        exp_q.push_back(32'h02);
        src = 8'h02; memAddr = B; memWriteData = 32'h02; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        rd(B, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL set_beats_clear got=%h want=%h", v, e); end
    endtask

    task automatic test_masked;
        wr(B, 32'hFF);
        wr(B + 4, 32'h00);
        src = 8'h00;
        @(negedge clk);
        src = 8'h20;
        repeat (2) @(negedge clk);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h20);
        exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h20);
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, irq} !== e) begin errs++; $display("FAIL masked_irq got=%b want=%h", irq, e); end
        rd(B + 8, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL masked_status got=%h want=%h", v, e); end
        rd(B, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL masked_pending got=%h want=%h", v, e); end
        wr(B + 4, 32'h20);
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, irq} !== e) begin errs++; $display("FAIL unmask_irq_k got=%b want=%h", irq, e); end
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, irq} !== e) begin errs++; $display("FAIL unmask_irq_k1 got=%b want=%h", irq, e); end
        rd(B + 8, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL unmask_status got=%h want=%h", v, e); end
    endtask

    task automatic test_level;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h20);
        wr(B, 32'h20);
        repeat (3) @(negedge clk);
        rd(B, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL level_pending got=%h want=%h", v, e); end
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, irq} !== e) begin errs++; $display("FAIL level_irq got=%b want=%h", irq, e); end
        src = 8'h00;
        @(negedge clk);
        src = 8'h20;
        @(negedge clk);
        rd(B, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL retrigger got=%h want=%h", v, e); end
    endtask

    task automatic test_bus;
        exp_q.push_back(32'h20); exp_q.push_back(32'h5A); exp_q.push_back(32'hFF);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        exp_q.push_back(32'h0); exp_q.push_back(32'hFF);
        @(negedge clk);
        memAddr = B + 4; memWriteData = 32'h5A; MemRead = 1'b1; MemWrite = 1'b1;
        #1;
        v = rdata; e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL rw_old_value got=%h want=%h", v, e); end
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        rd(B + 4, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL rw_written got=%h want=%h", v, e); end
        wr(B + 4, 32'hFFFF_FFFF);
        rd(B + 4, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL mask_upper got=%h want=%h", v, e); end
        rd(B + 32'h20, v, h); e = exp_q.pop_front(); vecs++;
        if ({31'd0, h} !== e) begin errs++; $display("FAIL miss_hit got=%b want=%h", h, e); end
        e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL miss_rdata got=%h want=%h", v, e); end
        rd(B + 32'h14, v, h); e = exp_q.pop_front(); vecs++;
        if ({31'd0, h} !== e) begin errs++; $display("FAIL unmapped_hit got=%b want=%h", h, e); end
        e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL unmapped_rdata got=%h want=%h", v, e); end
`ifndef IRQ_CTL_COUNT_EN
        rd(B + 32'h10, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL count_absent got=%h want=%h", v, e); end
`else
        void'(exp_q.pop_front());
`endif
        memAddr = B + 4; MemRead = 1'b0;
        #1;
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, hit} !== e) begin errs++; $display("FAIL noread_hit got=%b want=%h", hit, e); end
        e = exp_q.pop_front(); vecs++;
        if (rdata !== e) begin errs++; $display("FAIL noread_rdata got=%h want=%h", rdata, e); end
        rd(B + 7, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL byte_offset_ignored got=%h want=%h", v, e); end
    endtask

    task automatic test_reset_mid;
        src = 8'h00;
        @(negedge clk);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        reset = 1'b1; src = 8'h01; memAddr = B + 4; memWriteData = 32'h0F; MemWrite = 1'b1;
        @(negedge clk);
        reset = 1'b0; MemWrite = 1'b0;
        rd(B, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL midreset_pending got=%h want=%h", v, e); end
        rd(B + 4, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL midreset_mask got=%h want=%h", v, e); end
        e = exp_q.pop_front(); vecs++;
        if ({31'd0, irq} !== e) begin errs++; $display("FAIL midreset_irq got=%b want=%h", irq, e); end
    endtask

`ifdef IRQ_CTL_COUNT_EN
    task automatic test_count;
        exp_q.push_back(32'd2); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        wr(B + 32'h10, 32'd0);
        src = 8'h00;
        @(negedge clk);
        src = 8'h03;
        @(negedge clk);
        src = 8'h00;
        @(negedge clk);
        src = 8'h04;
        @(negedge clk);
        rd(B + 32'h10, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL count_two got=%h want=%h", v, e); end
        force dut.count = 32'hFFFF_FFFF;
        src = 8'h00;
        @(negedge clk);
        release dut.count;
        src = 8'h08;
        @(negedge clk);
        rd(B + 32'h10, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL count_wrap got=%h want=%h", v, e); end
        src = 8'h00;
        @(negedge clk);
        src = 8'h10; memAddr = B + 32'h10; memWriteData = 32'd0; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        rd(B + 32'h10, v, h); e = exp_q.pop_front(); vecs++;
        if (v !== e) begin errs++; $display("FAIL count_clear_wins got=%h want=%h", v, e); end
    endtask
`endif

    initial begin
        test_reset;
        test_edge;
        test_w1c;
        test_same_cycle;
        test_masked;
        test_level;
        test_bus;
        test_reset_mid;
`ifdef IRQ_CTL_COUNT_EN
        test_count;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/irq_ctl.md
IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 The block SHALL have parameter BASE, default 32'hFFFF_0000, meaning the base address of its 32-byte memory-mapped register window.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port src, input, 8 bits: interrupt source lines, rising-edge sensitive.
REQ-005 The block SHALL have port memAddr, input, 32 bits: CPU data address.
REQ-006 The block SHALL have port memWriteData, input, 32 bits: CPU store data.
REQ-007 The block SHALL have port MemRead, input, 1 bit: CPU load strobe.
REQ-008 The block SHALL have port MemWrite, input, 1 bit: CPU store strobe.
REQ-009 The block SHALL have port rdata, output, 32 bits: register read data for the CPU load mux.
REQ-010 The block SHALL have port hit, output, 1 bit: memAddr falls in the register window.
REQ-011 The block SHALL have port irq, output, 1 bit: registered interrupt request to the CPU irq input.

Function
REQ-012 hit SHALL equal (memAddr[31:5] == BASE[31:5]), combinationally; memAddr[1:0] ignored; register select = memAddr[4:2].
REQ-013 Register map SHALL be: 0x00 PENDING[7:0] (read; write-1-to-clear), 0x04 MASK[7:0] (read/write), 0x08 STATUS = PENDING & MASK (read-only), 0x0C ID (read-only), 0x10 COUNT (see Configuration); other offsets read 0, writes ignored; unused upper bits read 0.
REQ-014 ID SHALL read {valid, 26'd0, idx[4:0]}: valid = |STATUS, idx = lowest-numbered set STATUS bit; 32'd0 when STATUS is zero.
REQ-015 src_q SHALL register src every cycle; edge[i] = src[i] & ~src_q[i].
REQ-016 PENDING SHALL update each edge as (PENDING & ~clr) | edge, where clr = memWriteData[7:0] when hit & MemWrite & offset 0x00, else 0; a set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-017 MASK SHALL load memWriteData[7:0] on hit & MemWrite & offset 0x04.
REQ-018 irq SHALL be a flop loaded with |(PENDING & MASK) each cycle: a src rise sampled at edge k sets PENDING at edge k and asserts irq after edge k+1 if MASK is set.
REQ-019 rdata SHALL be combinational from current register values when hit & MemRead, else 32'd0; simultaneous MemRead and MemWrite SHALL return the pre-write value and perform the write.
REQ-020 Level-held sources SHALL not re-trigger; a new rising edge SHALL be required after PENDING is cleared.
REQ-021 MASK changes SHALL not alter PENDING; a masked pending bit SHALL raise irq one cycle after being unmasked.

Reset
REQ-022 On reset high at an edge: PENDING = 0, MASK = 0, irq = 0, COUNT = 0, src_q = 8'hFF, so sources already high at reset release SHALL not set PENDING.
REQ-023 Reset SHALL take priority over every write and edge in the same cycle, including mid-sequence.

Configuration
REQ-024 Macro IRQ_CTL_COUNT_EN defined: COUNT at 0x10 SHALL be a 32-bit counter that increments by 1 in each cycle where |edge is 1 (regardless of MASK), wraps 32'hFFFF_FFFF -> 0, and clears to 0 on any write to 0x10 (clear wins over increment).
REQ-025 Macro IRQ_CTL_COUNT_EN undefined: no COUNT storage SHALL exist; 0x10 SHALL read 0 and ignore writes.

Verification
REQ-026 Reset with src=8'h01 held, release, MASK=8'h01 -> PENDING stays 0, irq stays 0.
REQ-027 MASK=8'h04, src[2] 0->1 sampled at edge k -> PENDING=8'h04 after k, irq=1 after k+1, ID reads 32'h8000_0002.
REQ-028 PENDING=8'h0C, MASK=8'hFF, write 32'h04 to 0x00 -> PENDING=8'h08, ID=32'h8000_0003; write 32'h08 -> irq=0 one cycle later.
REQ-029 Same cycle: src[1] rising and W1C of bit 1 -> PENDING[1]=1 afterward.
REQ-030 MASK=0, src[5] rises -> irq=0, STATUS=0; write MASK=8'h20 -> irq=1 one cycle later.
REQ-031 With IRQ_CTL_COUNT_EN, COUNT preloaded via forced state 32'hFFFF_FFFF, one edge -> COUNT=0; without macro, read 0x10 -> 32'd0; read with memAddr=BASE+0x20 -> hit=0, rdata=0.
